// File: rtl/ncpu32k_issue_ctrl_pkg.sv
// Shared types for the issue stage: FU one-hot indices, FSM states, held uop fields.
package ncpu32k_issue_ctrl_pkg;

    localparam int NCPU_REG_AW  = 5;
    localparam int NCPU_REG_NUM = 1 << NCPU_REG_AW;

    localparam int NCPU_FU_W   = 5;
    localparam int NCPU_FU_ALU = 0;
    localparam int NCPU_FU_LPU = 1;
    localparam int NCPU_FU_BRU = 2;
    localparam int NCPU_FU_LSU = 3;
    localparam int NCPU_FU_EPU = 4;

    typedef enum logic [1:0] {
        ISS_ST_RUN    = 2'd0,
        ISS_ST_DRAIN  = 2'd1,
        ISS_ST_SERIAL = 2'd2
    } iss_state_t;

    typedef struct packed {
        logic [NCPU_FU_W-1:0]   fu;
        logic                   serial;
        logic                   rs1_re;
        logic                   rs2_re;
        logic [NCPU_REG_AW-1:0] rs1_addr;
        logic [NCPU_REG_AW-1:0] rs2_addr;
        logic                   wb_regf;
        logic [NCPU_REG_AW-1:0] wb_addr;
    } iss_uop_t;

endpackage

// File: rtl/ncpu32k_scoreboard.sv
// Pending-destination scoreboard: one set port, two clear ports, three lookups.
// Latency: lookups read registered state; updates visible the next cycle.
// Backpressure: none; set wins over clear on the same bit, r0 never pends.
module ncpu32k_scoreboard
    import ncpu32k_issue_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_en,
    input  logic [NCPU_REG_AW-1:0]  set_addr,
    input  logic                    clr0_en,
    input  logic [NCPU_REG_AW-1:0]  clr0_addr,
    input  logic                    clr1_en,
    input  logic [NCPU_REG_AW-1:0]  clr1_addr,
    input  logic [NCPU_REG_AW-1:0]  rd0_addr,
    input  logic [NCPU_REG_AW-1:0]  rd1_addr,
    input  logic [NCPU_REG_AW-1:0]  rd_wb_addr,
    output logic                    rd0_pend,
    output logic                    rd1_pend,
    output logic                    rd_wb_pend,
    output logic [NCPU_REG_NUM-1:0] pend
);

    logic [NCPU_REG_NUM-1:0] pend_q;
    logic [NCPU_REG_NUM-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend_q;
        if (clr0_en) pend_nxt[clr0_addr] = 1'b0;
        if (clr1_en) pend_nxt[clr1_addr] = 1'b0;
        if (set_en)  pend_nxt[set_addr]  = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_nxt;
    end

    assign rd0_pend   = pend_q[rd0_addr];
    assign rd1_pend   = pend_q[rd1_addr];
    assign rd_wb_pend = pend_q[rd_wb_addr];
    assign pend       = pend_q;

endmodule

// File: rtl/ncpu32k_issue_ctrl.sv
// Single-entry issue controller: holds one decoded op, checks RAW/WAW, issues to one FU.
// Latency: accept in cycle N, issue earliest N+1; one op per cycle when hazard-free.
// Backpressure: idu_ready drops while held op cannot fire; serializing ops drain the machine.
module ncpu32k_issue_ctrl
    import ncpu32k_issue_ctrl_pkg::*;
#(
    parameter int CONFIG_PAYLOAD_DW      = 64,
    parameter int CONFIG_LSU_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         idu_valid,
    output logic                         idu_ready,
    input  logic [NCPU_FU_W-1:0]         idu_fu,
    input  logic                         idu_serial,
    input  logic                         idu_rs1_re,
    input  logic                         idu_rs2_re,
    input  logic [NCPU_REG_AW-1:0]       idu_rs1_addr,
    input  logic [NCPU_REG_AW-1:0]       idu_rs2_addr,
    input  logic                         idu_wb_regf,
    input  logic [NCPU_REG_AW-1:0]       idu_wb_addr,
    input  logic [CONFIG_PAYLOAD_DW-1:0] idu_payload,
    output logic [NCPU_FU_W-1:0]         iss_valid,
    input  logic [NCPU_FU_W-1:0]         iss_ready,
    output logic [NCPU_REG_AW-1:0]       iss_rs1_addr,
    output logic [NCPU_REG_AW-1:0]       iss_rs2_addr,
    output logic [NCPU_REG_AW-1:0]       iss_wb_addr,
    output logic                         iss_wb_regf,
    output logic [CONFIG_PAYLOAD_DW-1:0] iss_payload,
    input  logic                         wb0_valid,
    input  logic [NCPU_REG_AW-1:0]       wb0_addr,
    input  logic                         wb1_valid,
    input  logic [NCPU_REG_AW-1:0]       wb1_addr,
    input  logic                         lsu_done,
    input  logic                         epu_done,
    output logic                         busy
);

    localparam logic [2:0] LSU_MAX = 3'(CONFIG_LSU_OUTSTANDING);

    iss_state_t                   state, state_nxt;
    logic                         hold_vld;
    iss_uop_t                     hold_uop;
    logic [CONFIG_PAYLOAD_DW-1:0] hold_payload;
    logic                         ser_barrier;
    logic [2:0]                   lsu_cnt;
    logic [NCPU_REG_NUM-1:0]      pend;
    logic                         rs1_pend, rs2_pend, wb_pend;
    logic                         src_haz, waw, lsu_full, machine_empty;
    logic                         fire, accept, lsu_fire;

    ncpu32k_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (fire & hold_uop.wb_regf),
        .set_addr   (hold_uop.wb_addr),
        .clr0_en    (wb0_valid),
        .clr0_addr  (wb0_addr),
        .clr1_en    (wb1_valid),
        .clr1_addr  (wb1_addr),
        .rd0_addr   (hold_uop.rs1_addr),
        .rd1_addr   (hold_uop.rs2_addr),
        .rd_wb_addr (hold_uop.wb_addr),
        .rd0_pend   (rs1_pend),
        .rd1_pend   (rs2_pend),
        .rd_wb_pend (wb_pend),
        .pend       (pend)
    );

    assign src_haz       = (hold_uop.rs1_re & rs1_pend) | (hold_uop.rs2_re & rs2_pend);
    assign waw           = hold_uop.wb_regf & wb_pend;
    assign lsu_full      = (lsu_cnt == LSU_MAX);
    assign machine_empty = ~|pend & (lsu_cnt == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ISS_ST_RUN;
        else        state <= state_nxt;
    end

    // Flush only aborts a drain; once a serializing op has issued it must complete.
    always_comb begin
        state_nxt = state;
        case (state)
            ISS_ST_RUN:    if (~flush & hold_vld & hold_uop.serial) state_nxt = ISS_ST_DRAIN;
            ISS_ST_DRAIN:  if (flush)                               state_nxt = ISS_ST_RUN;
                           else if (fire)                           state_nxt = ISS_ST_SERIAL;
            ISS_ST_SERIAL: if (ser_barrier | epu_done)              state_nxt = ISS_ST_RUN;
            default:                                                state_nxt = ISS_ST_RUN;
        endcase
    end

    always_comb begin
        iss_valid = '0;
        case (state)
            ISS_ST_RUN: begin
                if (hold_vld & ~hold_uop.serial & ~src_haz & ~waw) begin
                    iss_valid = hold_uop.fu;
                    if (lsu_full) iss_valid[NCPU_FU_LSU] = 1'b0;
                end
            end
            ISS_ST_DRAIN: if (hold_vld & machine_empty) iss_valid = hold_uop.fu;
            default: ;
        endcase
        if (flush) iss_valid = '0;
        fire      = |(iss_valid & iss_ready);
        idu_ready = ~flush & (~hold_vld | fire) & (state == ISS_ST_RUN);
    end

    assign accept   = idu_valid & idu_ready;
    assign lsu_fire = iss_valid[NCPU_FU_LSU] & iss_ready[NCPU_FU_LSU];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld     <= 1'b0;
            hold_uop     <= '0;
            hold_payload <= '0;
        end else if (flush) begin
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold_vld              <= 1'b1;
            hold_uop.fu           <= idu_fu;
            hold_uop.serial       <= idu_serial;
            hold_uop.rs1_re       <= idu_rs1_re;
            hold_uop.rs2_re       <= idu_rs2_re;
            hold_uop.rs1_addr     <= idu_rs1_addr;
            hold_uop.rs2_addr     <= idu_rs2_addr;
            hold_uop.wb_regf      <= idu_wb_regf;
            hold_uop.wb_addr      <= idu_wb_addr;
            hold_payload          <= idu_payload;
        end else if (fire) begin
            hold_vld <= 1'b0;
        end
    end

    // A barrier targets the LSU and needs only one SERIAL cycle, no epu_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  ser_barrier <= 1'b0;
        else if (state == ISS_ST_DRAIN && fire)      ser_barrier <= hold_uop.fu[NCPU_FU_LSU];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_cnt <= 3'd0;
        end else begin
            case ({lsu_fire, lsu_done})
                2'b10:   lsu_cnt <= lsu_cnt + 3'd1;
                2'b01:   if (lsu_cnt != 3'd0) lsu_cnt <= lsu_cnt - 3'd1;
                default: lsu_cnt <= lsu_cnt;
            endcase
        end
    end

    assign iss_rs1_addr = hold_uop.rs1_addr;
    assign iss_rs2_addr = hold_uop.rs2_addr;
    assign iss_wb_addr  = hold_uop.wb_addr;
    assign iss_wb_regf  = hold_uop.wb_regf;
    assign iss_payload  = hold_payload;

    assign busy = hold_vld | (|pend) | (lsu_cnt != 3'd0) | (state != ISS_ST_RUN);

    a_iss_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(iss_valid));
    a_lsu_bound:  assert property (@(posedge clk) disable iff (!rst_n) lsu_cnt <= LSU_MAX);

endmodule

// File: tb/tb_ncpu32k_issue_ctrl.sv
// Directed bench: expected issues queued at accept, popped by a monitor on each fire.
module tb_ncpu32k_issue_ctrl;
    import ncpu32k_issue_ctrl_pkg::*;

    localparam logic [4:0] FU_ALU = 5'b00001;
    localparam logic [4:0] FU_LSU = 5'b01000;
    localparam logic [4:0] FU_EPU = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        idu_valid = 1'b0;
    logic        idu_ready;
    logic [4:0]  idu_fu = '0;
    logic        idu_serial = 1'b0;
    logic        idu_rs1_re = 1'b0, idu_rs2_re = 1'b0;
    logic [4:0]  idu_rs1_addr = '0, idu_rs2_addr = '0;
    logic        idu_wb_regf = 1'b0;
    logic [4:0]  idu_wb_addr = '0;
    logic [63:0] idu_payload = '0;
    logic [4:0]  iss_valid;
    logic [4:0]  iss_ready = 5'b11111;
    logic [4:0]  iss_rs1_addr, iss_rs2_addr, iss_wb_addr;
    logic        iss_wb_regf;
    logic [63:0] iss_payload;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [4:0]  wb0_addr = '0, wb1_addr = '0;
    logic        lsu_done = 1'b0, epu_done = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    ncpu32k_issue_ctrl #(.CONFIG_PAYLOAD_DW(64), .CONFIG_LSU_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_fu(idu_fu), .idu_serial(idu_serial),
        .idu_rs1_re(idu_rs1_re), .idu_rs2_re(idu_rs2_re),
        .idu_rs1_addr(idu_rs1_addr), .idu_rs2_addr(idu_rs2_addr),
        .idu_wb_regf(idu_wb_regf), .idu_wb_addr(idu_wb_addr), .idu_payload(idu_payload),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr), .iss_wb_addr(iss_wb_addr),
        .iss_wb_regf(iss_wb_regf), .iss_payload(iss_payload),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb1_valid(wb1_valid), .wb1_addr(wb1_addr),
        .lsu_done(lsu_done), .epu_done(epu_done), .busy(busy)
    );

    typedef struct {
        logic [4:0]  fu;
        logic [4:0]  wb;
        logic [63:0] pl;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] fu, input logic serial,
                        input logic rs1_re, input logic [4:0] rs1,
                        input logic rs2_re, input logic [4:0] rs2,
                        input logic wb_regf, input logic [4:0] wb,
                        input logic [63:0] pl, input bit expect_iss, output int waited);
        idu_fu = fu; idu_serial = serial;
        idu_rs1_re = rs1_re; idu_rs1_addr = rs1;
        idu_rs2_re = rs2_re; idu_rs2_addr = rs2;
        idu_wb_regf = wb_regf; idu_wb_addr = wb; idu_payload = pl;
        idu_valid = 1'b1;
        waited = 0;
        #1;
        while (!idu_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!idu_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            idu_valid = 1'b0;
            tick();
            return;
        end
        if (expect_iss) exp_q.push_back('{fu, wb, pl});
        tick();
        idu_valid = 1'b0;
    endtask

    // Scoreboard monitor: every fire must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n && |(iss_valid & iss_ready)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {59'd0, iss_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_fu", {59'd0, iss_valid}, {59'd0, e.fu});
                chk("mon_wb", {59'd0, iss_wb_addr}, {59'd0, e.wb});
                chk("mon_payload", iss_payload, e.pl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_iss_valid", {59'd0, iss_valid}, 64'd0);
        chk("rst_idu_ready", {63'd0, idu_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_payload", iss_payload, 64'd0);
        chk("rst_wb_addr", {59'd0, iss_wb_addr}, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // Independent ALU ops back-to-back
        iss_ready = FU_ALU;
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd1, 64'h101, 1, w);
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd2, 64'h102, 1, w);
        chk("t1_b2b_1", 64'(w), 64'd0);
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 64'h107, 1, w);
        chk("t1_b2b_2", 64'(w), 64'd0);
        #1 chk("t1_i3_valid", {59'd0, iss_valid}, {59'd0, FU_ALU});
        tick();
        #1;
        chk("t1_idle_valid", {59'd0, iss_valid}, 64'd0);
        chk("t1_busy_pend", {63'd0, busy}, 64'd1);
        wb0_valid = 1; wb0_addr = 5'd1; wb1_valid = 1; wb1_addr = 5'd2;
        tick();
        wb1_valid = 0; wb0_addr = 5'd7;
        #1 chk("t1_busy_r7", {63'd0, busy}, 64'd1);
        tick();
        wb0_valid = 0;
        #1 chk("t1_busy_clear", {63'd0, busy}, 64'd0);

        // RAW: ADD r3 then ADD r4 <- r3
        iss_ready = 5'b11111;
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd3, 64'h203, 1, w);
        send(FU_ALU, 0, 1, 5'd3, 0, 5'd0, 1, 5'd4, 64'h204, 1, w);
        #1 chk("t2_stall0", {59'd0, iss_valid}, 64'd0);
        tick();
        #1 chk("t2_stall1", {59'd0, iss_valid}, 64'd0);
        tick();
        wb0_valid = 1; wb0_addr = 5'd3;
        #1 chk("t2_no_bypass", {59'd0, iss_valid}, 64'd0);
        tick();
        wb0_valid = 0;
        #1 chk("t2_release", {59'd0, iss_valid}, {59'd0, FU_ALU});
        tick();
        wb0_valid = 1; wb0_addr = 5'd4;
        tick();
        wb0_valid = 0;
        #1 chk("t2_busy_clear", {63'd0, busy}, 64'd0);

        // LSU outstanding limit of two
        send(FU_LSU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd8,  64'h308, 1, w);
        send(FU_LSU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9,  64'h309, 1, w);
        send(FU_LSU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd10, 64'h30A, 1, w);
        #1;
        chk("t3_full", {59'd0, iss_valid}, 64'd0);
        chk("t3_full_rdy", {63'd0, idu_ready}, 64'd0);
        tick();
        #1 chk("t3_full_hold", {59'd0, iss_valid}, 64'd0);
        lsu_done = 1;
        #1 chk("t3_done_same_cycle", {59'd0, iss_valid}, 64'd0);
        tick();
        lsu_done = 0;
        #1 chk("t3_release", {59'd0, iss_valid}, {59'd0, FU_LSU});
        tick();
        lsu_done = 1; wb0_valid = 1; wb0_addr = 5'd8; wb1_valid = 1; wb1_addr = 5'd9;
        tick();
        wb0_addr = 5'd10; wb1_valid = 0;
        tick();
        lsu_done = 0; wb0_valid = 0;
        #1 chk("t3_busy_clear", {63'd0, busy}, 64'd0);

        // WMSR behind pending r5 and one LSU op
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5, 64'h405, 1, w);
        send(FU_LSU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd6, 64'h406, 1, w);
        send(FU_EPU, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 64'h4E0, 1, w);
        #1;
        chk("t4_run_hold", {59'd0, iss_valid}, 64'd0);
        chk("t4_run_rdy", {63'd0, idu_ready}, 64'd0);
        tick();
        #1;
        chk("t4_drain_wait", {59'd0, iss_valid}, 64'd0);
        chk("t4_drain_busy", {63'd0, busy}, 64'd1);
        wb0_valid = 1; wb0_addr = 5'd5; wb1_valid = 1; wb1_addr = 5'd6;
        tick();
        wb0_valid = 0; wb1_valid = 0;
        #1 chk("t4_drain_lsu", {59'd0, iss_valid}, 64'd0);
        lsu_done = 1;
        tick();
        lsu_done = 0;
        #1 chk("t4_drain_issue", {59'd0, iss_valid}, {59'd0, FU_EPU});
        tick();
        #1;
        chk("t4_serial_rdy", {63'd0, idu_ready}, 64'd0);
        chk("t4_serial_valid", {59'd0, iss_valid}, 64'd0);
        tick();
        #1 chk("t4_serial_hold", {63'd0, idu_ready}, 64'd0);
        epu_done = 1;
        tick();
        epu_done = 0;
        #1;
        chk("t4_back_run", {63'd0, idu_ready}, 64'd1);
        chk("t4_busy_clear", {63'd0, busy}, 64'd0);

        // Memory barrier: one SERIAL cycle, no epu_done
        send(FU_LSU, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 64'h4B0, 1, w);
        tick();
        #1 chk("t4b_drain_issue", {59'd0, iss_valid}, {59'd0, FU_LSU});
        tick();
        #1 chk("t4b_serial", {63'd0, idu_ready}, 64'd0);
        tick();
        #1 chk("t4b_run", {63'd0, idu_ready}, 64'd1);
        lsu_done = 1;
        tick();
        lsu_done = 0;
        #1 chk("t4b_busy_clear", {63'd0, busy}, 64'd0);

        // Flush a hazarded op; simultaneous idu_valid is refused
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd11, 64'h50B, 1, w);
        send(FU_ALU, 0, 0, 5'd0, 1, 5'd11, 1, 5'd12, 64'h50C, 0, w);
        #1 chk("t5_stalled", {59'd0, iss_valid}, 64'd0);
        flush = 1;
        idu_fu = FU_ALU; idu_serial = 0; idu_rs1_re = 0; idu_rs2_re = 0;
        idu_wb_regf = 1; idu_wb_addr = 5'd13; idu_payload = 64'h5FF;
        idu_valid = 1;
        #1;
        chk("t5_flush_noacc", {63'd0, idu_ready}, 64'd0);
        chk("t5_flush_valid", {59'd0, iss_valid}, 64'd0);
        tick();
        flush = 0; idu_valid = 0;
        #1;
        chk("t5_hold_cleared", {63'd0, idu_ready}, 64'd1);
        chk("t5_pend_kept", {63'd0, busy}, 64'd1);
        wb0_valid = 1; wb0_addr = 5'd11;
        tick();
        wb0_valid = 0;
        #1;
        chk("t5_killed", {59'd0, iss_valid}, 64'd0);
        chk("t5_busy_clear", {63'd0, busy}, 64'd0);

        // Flush during DRAIN
        send(FU_ALU, 0, 0, 5'd0, 0, 5'd0, 1, 5'd13, 64'h51D, 1, w);
        send(FU_EPU, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 64'h5E0, 0, w);
        tick();
        #1 chk("t5b_drain", {63'd0, idu_ready}, 64'd0);
        flush = 1;
        tick();
        flush = 0;
        #1;
        chk("t5b_run", {63'd0, idu_ready}, 64'd1);
        chk("t5b_pend_kept", {63'd0, busy}, 64'd1);
        wb0_valid = 1; wb0_addr = 5'd13;
        tick();
        wb0_valid = 0;
        #1;
        chk("t5b_busy_clear", {63'd0, busy}, 64'd0);
        chk("t5b_no_issue", {59'd0, iss_valid}, 64'd0);

        // Reset in SERIAL with a pending destination
        send(FU_EPU, 1, 0, 5'd0, 0, 5'd0, 1, 5'd15, 64'h6E0, 1, w);
        tick();
        #1 chk("t6_drain_issue", {59'd0, iss_valid}, {59'd0, FU_EPU});
        tick();
        #1;
        chk("t6_serial_busy", {63'd0, busy}, 64'd1);
        chk("t6_serial_rdy", {63'd0, idu_ready}, 64'd0);
        rst_n = 0;
        #1;
        chk("t6_rst_valid", {59'd0, iss_valid}, 64'd0);
        chk("t6_rst_rdy", {63'd0, idu_ready}, 64'd1);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_wb_addr", {59'd0, iss_wb_addr}, 64'd0);
        chk("t6_rst_payload", iss_payload, 64'd0);
        #3 rst_n = 1;
        tick();
        #1;
        chk("t6_post_rdy", {63'd0, idu_ready}, 64'd1);
        chk("t6_post_busy", {63'd0, busy}, 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ncpu32k_issue_ctrl.md
# ncpu32k_issue_ctrl

Single-entry issue controller between the instruction decoder and the functional units (ALU, LPU, BRU, LSU, EPU). It holds one decoded instruction and tracks pending destination registers in a 32-entry scoreboard. It issues the instruction to exactly one unit once RAW/WAW hazards and unit back-pressure allow. Serializing instructions (EPU ops, memory barrier) run alone, after the machine drains and before anything younger issues.

## Interface
- CONFIG_PAYLOAD_DW, 64, width of opaque decoded payload (opcode buses, imm32, LSU size/sign) carried to units
- CONFIG_LSU_OUTSTANDING, 2, max LSU ops issued but not done (1..7)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill held instruction, abort drain
- idu_valid  in  1  decoded instruction available
- idu_ready  out  1  hold register can accept
- idu_fu  in  5  one-hot target unit {EPU,LSU,BRU,LPU,ALU} = bits [4:0]
- idu_serial  in  1  serializing op (EPU op or op_lsu_barr)
- idu_rs1_re, idu_rs2_re  in  1 each  source read enables
- idu_rs1_addr, idu_rs2_addr  in  `NCPU_REG_AW each  source registers
- idu_wb_regf  in  1  writes a register (never r0)
- idu_wb_addr  in  `NCPU_REG_AW  destination register
- idu_payload  in  CONFIG_PAYLOAD_DW  opaque payload
- iss_valid  out  5  one-hot issue strobe per unit
- iss_ready  in  5  unit can accept
- iss_rs1_addr, iss_rs2_addr, iss_wb_addr  out  `NCPU_REG_AW each  held fields
- iss_wb_regf  out  1  held write-enable
- iss_payload  out  CONFIG_PAYLOAD_DW  held payload
- wb0_valid, wb1_valid  in  1 each  register writeback commit ports
- wb0_addr, wb1_addr  in  `NCPU_REG_AW each  committed destinations
- lsu_done  in  1  one LSU op retired
- epu_done  in  1  serializing op finished
- busy  out  1  hold valid, any scoreboard bit set, LSU count nonzero, or FSM not RUN

## Operation
- Accept: on idu_valid & idu_ready, capture all idu_* into the hold register and set hold_vld. idu_ready = ~flush & (~hold_vld | fire) & (state==RUN).
- Hazard: src_haz = (rs1_re & pend[rs1]) | (rs2_re & pend[rs2]). waw = wb_regf & pend[wb_addr]. pend[0] is always 0.
- Normal issue (idu_serial=0): iss_valid = hold fu & {5{hold_vld & ~src_haz & ~waw & state==RUN}}, with the LSU bit also masked when lsu_cnt==CONFIG_LSU_OUTSTANDING. fire = |(iss_valid & iss_ready). iss_valid holds stable until fire or flush.
- Scoreboard: on fire with wb_regf, set pend[wb_addr]. wb0/wb1 commits clear their bit; commits to r0 are ignored. If set and clear hit the same bit in one cycle, set wins. If both wb ports name the same register, it is cleared once.
- LSU counter: +1 on LSU fire, -1 on lsu_done; both together leave it unchanged. Saturation is guaranteed by the masking above; lsu_done at 0 is a protocol error and leaves the count at 0.
- FSM:
  - RUN → DRAIN: hold_vld & serial.
  - DRAIN → SERIAL: pend==0 & lsu_cnt==0. In DRAIN, iss_valid asserts toward the target when empty; transition occurs on fire.
  - SERIAL → RUN: on epu_done. For a barrier (LSU target), the FSM returns to RUN on the cycle after fire.
- Flush: clears hold_vld and moves DRAIN → RUN. In SERIAL, flush does not abort; the FSM waits for epu_done. The scoreboard and LSU count are unaffected, because in-flight ops still commit.

## Timing
- Reset values: hold_vld=0, pend=0, lsu_cnt=0, state=RUN. Outputs: iss_valid=0, iss_* fields and iss_payload=0, idu_ready=1, busy=0.
- Latency: instruction accepted in cycle N → iss_valid earliest in N+1.
- Back-to-back: idu_ready=1 in the fire cycle, giving one instruction per cycle with no hazards.
- Hazard check uses registered pend only. A wb commit in cycle N releases a dependent instruction in N+1 (no same-cycle bypass).
- flush takes priority over accept and over fire in the same cycle. iss_valid is driven 0 whenever flush=1.

## Structure
- Add to ncpu32k_config.h: FU one-hot index defines (NCPU_FU_ALU..NCPU_FU_EPU, width 5) and FSM state encodings.
- One sub-module, ncpu32k_scoreboard: pend vector, one set port, two clear ports, and two combinational lookup ports plus a dest lookup.
- Assertions: iss_valid is one-hot or zero; lsu_cnt never exceeds CONFIG_LSU_OUTSTANDING.

## Test plan
- Independent ALU ops back-to-back with iss_ready=5'b00001 → one fire per cycle, pend[wb] set, busy=1 until wb0 clears.
- ADD r3 then ADD r4←r3: the second stalls until wb0_valid/wb0_addr=3 in cycle N, then issues at N+1.
- Three LSU loads with CONFIG_LSU_OUTSTANDING=2 and no lsu_done → third held, iss_valid[3]=0; one lsu_done → issues next cycle.
- WMSR behind pending r5 and one LSU op → FSM DRAIN until pend==0 and lsu_cnt==0, then issue to EPU, SERIAL; idu_ready=0 until epu_done, then RUN.
- flush while holding a hazarded op and while in DRAIN → hold_vld=0, FSM RUN, pend and lsu_cnt unchanged; flush and idu_valid in the same cycle → not accepted.
- Reset asserted mid-SERIAL with pend≠0 → all outputs at reset values, idu_ready=1 immediately.
